// File: rtl/dmem_responder.sv
// Data-memory responder for the core's M-stage port: asynchronous-read word RAM
// plus an MMIO window holding a free-running cycle counter and a byte output FIFO.
module dmem_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    localparam logic [7:0] OFS_CYCLE  = 8'h00;
    localparam logic [7:0] OFS_TXDATA = 8'h04;
    localparam logic [7:0] OFS_STATUS = 8'h08;

    logic [31:0]   mem [RAM_WORDS];
    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [31:0]   cycleCnt;

    logic          isMmio;
    logic [7:0]    offset;
    logic [AW-1:0] ramIdx;
    logic          txWrite;
    logic          statusWrite;
    logic          pop;
    logic          push;
    logic          full;
    logic          empty;
    logic          unusedAddr;

    assign isMmio = (addr[31:28] == 4'hF);
    assign offset = addr[7:0];
    assign ramIdx = addr[AW+1:2];
    assign unusedAddr = ^addr;

    assign full  = (count == DEPTH);
    assign empty = (count == '0);

    // MMIO stores are masked during reset; RAM stores are not.
    assign txWrite     = we && isMmio && (offset == OFS_TXDATA) && !rst;
    assign statusWrite = we && isMmio && (offset == OFS_STATUS) && !rst;

    assign pop  = !empty && out_ready;
    assign push = txWrite && (!full || pop);

    assign out_valid = !empty;
    assign out_data  = fifoMem[rdPtr];

    always_comb begin
        rdata = '0;
        if (!isMmio) begin
            rdata = mem[ramIdx];
        end else begin
            case (offset)
                OFS_CYCLE:  rdata = cycleCnt;
                OFS_TXDATA: rdata = {{(32 - CW){1'b0}}, count};
                OFS_STATUS: rdata = {29'b0, overflow, empty, full};
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we && !isMmio) begin
            mem[ramIdx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycleCnt <= '0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped byte sets overflow even if the same cycle tries to clear it.
            if (txWrite && !push) begin
                overflow <= 1'b1;
            end else if (statusWrite && wdata[2]) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder: RAM aliasing, cycle counter,
// FIFO fill/overflow/drain, simultaneous push/pop and mid-stream reset.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic [31:0] expR;
        logic        expV;
        logic [7:0]  expD;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .wdata(wdata),
        .we(we),
        .rdata(rdata),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void addv(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic r, input logic [31:0] er, input logic ev,
                                 input logic [7:0] ed);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.rdy = r;
        v.expR = er; v.expV = ev; v.expD = ed;
        vecs.push_back(v);
    endfunction

    // Drive one cycle's inputs at the falling edge and check pre-edge outputs.
    task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
        @(negedge clk);
        we = w; addr = a; wdata = d; out_ready = r;
        #1;
    endtask

    localparam logic [31:0] A_CYC = 32'hF000_0000;
    localparam logic [31:0] A_TX  = 32'hF000_0004;
    localparam logic [31:0] A_ST  = 32'hF000_0008;

    initial begin
        rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);

        // Cycle counter after release
        @(negedge clk);
        rst = 1'b0; addr = A_CYC;
        #1 chk("cycle_0", rdata, 32'd0);
        @(negedge clk);
        #1 chk("cycle_1", rdata, 32'd1);
        repeat (9) @(negedge clk);
        #1 chk("cycle_10", rdata, 32'd10);

        @(negedge clk);
        force dut.cycleCnt = 32'hFFFF_FFFF;
        #1 release dut.cycleCnt;
        @(negedge clk);
        #1 chk("cycle_wrap", rdata, 32'd0);

        // RAM store/load, aliasing, read-during-write
        cyc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        cyc(1'b1, 32'h0000_0004, 32'hAAAA_5555, 1'b0);
        cyc(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        chk("ram_load", rdata, 32'hDEAD_BEEF);
        addr = 32'h0000_0112;
        #1 chk("ram_alias", rdata, 32'hDEAD_BEEF);
        cyc(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0);
        chk("ram_rdw_old", rdata, 32'hDEAD_BEEF);
        cyc(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        chk("ram_rdw_new", rdata, 32'h1234_5678);

        // FIFO fill, overflow, drain, clear
        addv(1, A_TX, 32'h41, 0, 32'd0, 0, 8'h00);
        addv(1, A_TX, 32'h42, 0, 32'd1, 1, 8'h41);
        addv(1, A_TX, 32'h43, 0, 32'd2, 1, 8'h41);
        addv(1, A_TX, 32'h44, 0, 32'd3, 1, 8'h41);
        addv(0, A_TX, 32'h00, 0, 32'd4, 1, 8'h41);
        addv(0, A_ST, 32'h00, 0, 32'h1, 1, 8'h41);
        addv(1, A_TX, 32'h45, 0, 32'd4, 1, 8'h41);
        addv(0, A_ST, 32'h00, 0, 32'h5, 1, 8'h41);
        addv(0, A_TX, 32'h00, 0, 32'd4, 1, 8'h41);
        addv(0, A_ST, 32'h00, 1, 32'h5, 1, 8'h41);
        addv(0, A_ST, 32'h00, 1, 32'h4, 1, 8'h42);
        addv(0, A_ST, 32'h00, 1, 32'h4, 1, 8'h43);
        addv(0, A_ST, 32'h00, 1, 32'h4, 1, 8'h44);
        addv(0, A_ST, 32'h00, 1, 32'h6, 0, 8'h00);
        addv(1, A_ST, 32'h04, 0, 32'h6, 0, 8'h00);
        addv(0, A_ST, 32'h00, 0, 32'h2, 0, 8'h00);
        addv(1, A_ST, 32'h00, 0, 32'h2, 0, 8'h00);
        addv(0, A_ST, 32'h00, 0, 32'h2, 0, 8'h00);
        // Full FIFO with simultaneous push and pop
        addv(1, A_TX, 32'h51, 0, 32'd0, 0, 8'h00);
        addv(1, A_TX, 32'h52, 0, 32'd1, 1, 8'h51);
        addv(1, A_TX, 32'h53, 0, 32'd2, 1, 8'h51);
        addv(1, A_TX, 32'h54, 0, 32'd3, 1, 8'h51);
        addv(1, A_TX, 32'h55, 1, 32'd4, 1, 8'h51);
        addv(0, A_TX, 32'h00, 0, 32'd4, 1, 8'h52);
        addv(0, A_ST, 32'h00, 1, 32'h1, 1, 8'h52);
        addv(0, A_ST, 32'h00, 1, 32'h4 & 32'h0, 1, 8'h53);
        addv(0, A_ST, 32'h00, 1, 32'h0, 1, 8'h54);
        addv(0, A_ST, 32'h00, 1, 32'h0, 1, 8'h55);
        addv(0, A_ST, 32'h00, 1, 32'h2, 0, 8'h00);
        // Decode corners
        addv(0, 32'hF000_00FC, 32'h0, 0, 32'h0, 0, 8'h00);
        addv(1, 32'hF000_000C, 32'hFFFF_FFFF, 0, 32'h0, 0, 8'h00);
        addv(0, 32'hFFFF_FF08, 32'h0, 0, 32'h2, 0, 8'h00);
        addv(0, 32'h0000_0004, 32'h0, 0, 32'hAAAA_5555, 0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].expR);
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].expV});
            if (vecs[i].expV) begin
                chk($sformatf("vec%0d_data", i), {24'b0, out_data}, {24'b0, vecs[i].expD});
            end
        end

        // Mid-stream reset with three bytes queued
        cyc(1'b1, A_TX, 32'h61, 1'b0);
        cyc(1'b1, A_TX, 32'h62, 1'b0);
        cyc(1'b1, A_TX, 32'h63, 1'b0);
        cyc(1'b0, A_TX, 32'h0, 1'b0);
        chk("pre_rst_count", rdata, 32'd3);
        @(negedge clk);
        rst = 1'b1; we = 1'b1; addr = A_TX; wdata = 32'h77;
        @(negedge clk);
        we = 1'b1; addr = 32'h0000_0020; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1'b0; we = 1'b0; addr = A_CYC;
        #1 chk("rst_cycle", rdata, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        addr = A_TX;
        #1 chk("rst_count", rdata, 32'd0);
        addr = A_ST;
        #1 chk("rst_status", rdata, 32'h2);
        addr = 32'h0000_0010;
        #1 chk("rst_ram_keep", rdata, 32'h1234_5678);
        addr = 32'h0000_0020;
        #1 chk("rst_ram_write", rdata, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's M-stage load/store port. The core drives address, write data and write enable; this block returns read data in the same cycle, and the core registers it into W.
- Contains a word-addressed RAM and a small memory-mapped I/O window: a free-running cycle counter and a byte output FIFO.
- The FIFO drains through a valid/ready stream port to an external sink (console/UART model).

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- addr  in  32  byte address from core (ALU result, M stage)
- wdata  in  32  store data from core
- we  in  1  store enable (already qualified by condition)
- rdata  out  32  load data, combinational from addr
- out_data  out  8  FIFO head byte
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  sink accepts head byte this cycle

Behaviour:
- Address decode:
  - addr[31:28]==4'hF selects MMIO; otherwise RAM.
  - addr[1:0] ignored everywhere (word access only).
- RAM:
  - Index = addr[log2(RAM_WORDS)+1:2]. Upper bits are ignored, so addresses alias/wrap.
  - Read is asynchronous: rdata = mem[index] in the same cycle.
  - Write on posedge clk when we and RAM selected.
  - Read-during-write to the same word returns the old value until the edge.
  - RAM contents are not cleared by rst.
- MMIO registers (offset = addr[7:0]; addr[27:8] ignored):
  - 0x00 CYCLE (RO):
    - 32-bit counter, 0 on rst, +1 every cycle after.
    - Wraps 0xFFFFFFFF -> 0.
    - Read returns the pre-edge value. Writes are ignored.
  - 0x04 TXDATA:
    - Write pushes wdata[7:0] into the FIFO.
    - Read returns {zero-extended count}, the number of occupied entries (0..FIFO_DEPTH).
  - 0x08 STATUS:
    - Read returns {29'b0, overflow, empty, full}.
    - Write with wdata[2]==1 clears overflow; other bits are read-only.
  - Other offsets read 0; writes are ignored.
- FIFO:
  - Circular buffer with rd/wr pointers and a count.
  - out_data = head entry. out_valid = (count != 0).
  - Pop when out_valid && out_ready.
  - Push when a TXDATA write occurs and (count < FIFO_DEPTH, or a pop happens in the same cycle).
  - Push while full with no pop: byte is dropped, no state change except overflow <= 1 (sticky).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - A pop with count==0 cannot occur because out_valid is 0.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow clear and overflow set in the same cycle: set wins.
- Reset:
  - Synchronous; takes effect at the edge even mid-stream.
  - Count=0, pointers=0, overflow=0, CYCLE=0.
  - out_valid=0 the cycle after rst is sampled.
  - Stores presented during rst are ignored for MMIO; RAM writes still occur.
- Latency:
  - Loads are 0-cycle combinational.
  - A FIFO push is visible on out_valid/out_data the cycle after the write edge.
- Reads have no side effects.

Test Plan:
- Store 0xDEADBEEF to 0x00000010, load 0x10 next cycle -> rdata=0xDEADBEEF. Load 0x00000112 (aliases index 4 with RAM_WORDS=64) -> 0xDEADBEEF.
- Release rst, read 0xF0000000 at cycles 0, 1 and 10 after release -> 0, 1, 10. Preload counter near wrap via force to 0xFFFFFFFF -> next read 0.
- out_ready=0; write 0x41, 0x42, 0x43, 0x44 to 0xF0000004:
  - TXDATA read -> 4; STATUS -> 0x1.
  - Fifth write 0x45 -> STATUS 0x5, count stays 4.
  - Drain with out_ready=1 -> out_data 0x41, 0x42, 0x43, 0x44 on consecutive cycles, then out_valid=0, STATUS 0x6.
- FIFO full, out_ready=1, write 0x55 in the same cycle -> accepted, no overflow, last drained byte 0x55.
- Set overflow, then write 0x4 to 0xF0000008 -> STATUS bit2=0. Write 0x0 -> no change.
- FIFO holding 3 bytes, assert rst for one cycle -> out_valid=0, TXDATA read 0, CYCLE 0. Previously stored RAM word is unchanged.
